// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b type package: word, cache-line and memory-arbiter state types.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum bit [1:0] {
    arb_idle,
    arb_serve_i,
    arb_serve_d
  } lc3b_arb_state;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// sat_counter16: 16-bit counter that increments on inc and sticks at 16'hFFFF.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high clear
//   inc   - count enable (one step per cycle)
//   count - current value
module sat_counter16
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)                           r_count <= '0;
    else if (inc && r_count != SAT_MAX) r_count <= r_count + 16'd1;
  end

  assign count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical-memory line port between the
// I-cache and D-cache. One requester is served at a time; simultaneous
// requests from IDLE alternate between the caches. Per-cache grant counts
// saturate at 16'hFFFF.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   i_read/i_address         - I-cache line read request
//   i_resp/i_rdata           - I-cache completion / line data
//   d_read/d_write/d_address/d_wdata - D-cache read or writeback request
//   d_resp/d_rdata           - D-cache completion / line data
//   pmem_*                   - physical memory port
//   i_grants/d_grants        - saturating grant counters
module mem_arbiter
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  lc3b_word    i_address,
  output logic        i_resp,
  output lc3b_c_line  i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  lc3b_word    d_address,
  input  lc3b_c_line  d_wdata,
  output logic        d_resp,
  output lc3b_c_line  d_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output lc3b_word    pmem_address,
  output lc3b_c_line  pmem_wdata,
  input  logic        pmem_resp,
  input  lc3b_c_line  pmem_rdata,
  output logic [15:0] i_grants,
  output logic [15:0] d_grants
);

  lc3b_arb_state r_state, w_state_nxt;
  logic          r_last_d;  // most recent grant went to the D-cache
  logic          w_i_req, w_d_req, w_grant_i, w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  always_comb begin
    w_state_nxt  = r_state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      arb_idle: begin
        // tie goes to whichever side did not win last time
        if (w_i_req && w_d_req) w_state_nxt = r_last_d ? arb_serve_i : arb_serve_d;
        else if (w_i_req)       w_state_nxt = arb_serve_i;
        else if (w_d_req)       w_state_nxt = arb_serve_d;
      end
      arb_serve_i: begin
        pmem_read    = i_read;
        pmem_address = i_address;
        i_resp       = pmem_resp;
        if (pmem_resp) w_state_nxt = arb_idle;
      end
      arb_serve_d: begin
        // read+write together is illegal; the write takes precedence
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write;
        pmem_address = d_address;
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
        if (pmem_resp) w_state_nxt = arb_idle;
      end
      default: w_state_nxt = arb_idle;
    endcase
  end

  assign w_grant_i = (r_state == arb_idle) && (w_state_nxt == arb_serve_i);
  assign w_grant_d = (r_state == arb_idle) && (w_state_nxt == arb_serve_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= arb_idle;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i || w_grant_d) r_last_d <= w_grant_d;
    end
  end

  // read data is broadcast; only the resp strobe is steered
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  sat_counter16 u_i_cnt (.clk(clk), .rst(rst), .inc(w_grant_i), .count(i_grants));
  sat_counter16 u_d_cnt (.clk(clk), .rst(rst), .inc(w_grant_d), .count(d_grants));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_read, d_read, d_write, pmem_resp;
  lc3b_word   i_address, d_address;
  lc3b_c_line d_wdata, pmem_rdata;
  logic       i_resp, d_resp, pmem_read, pmem_write;
  lc3b_c_line i_rdata, d_rdata, pmem_wdata;
  lc3b_word   pmem_address;
  logic [15:0] i_grants, d_grants;

  int n_chk = 0;
  int n_fail = 0;

  localparam lc3b_word   IA = 16'h0040;
  localparam lc3b_word   DA = 16'h1230;
  localparam lc3b_c_line WD = {4{32'hDEADBEEF}};
  localparam lc3b_c_line RD = {16{8'hA5}};

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ir, dr, dw, presp;
    logic e_pr, e_pw, e_ir, e_dr;
    logic [15:0] e_addr;
    logic e_wd;
    logic [15:0] e_ig, e_dg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, ir, dr, dw, pr_in,
                              input logic pr, pw, irs, drs,
                              input logic [15:0] a, input logic wd,
                              input logic [15:0] ig, dg);
    vec_t v;
    v.rst = r; v.ir = ir; v.dr = dr; v.dw = dw; v.presp = pr_in;
    v.e_pr = pr; v.e_pw = pw; v.e_ir = irs; v.e_dr = drs;
    v.e_addr = a; v.e_wd = wd; v.e_ig = ig; v.e_dg = dg;
    return v;
  endfunction

  function automatic logic [511:0] pk(input logic pr, pw, irs, drs, input logic [15:0] a,
                                      input lc3b_c_line wd, input logic [15:0] ig, dg,
                                      input lc3b_c_line ird, drd);
    return {76'b0, pr, pw, irs, drs, a, wd, ig, dg, ird, drd};
  endfunction

  function automatic logic [511:0] dut_pk();
    return pk(pmem_read, pmem_write, i_resp, d_resp, pmem_address, pmem_wdata,
              i_grants, d_grants, i_rdata, d_rdata);
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model state
  int   m_own;     // 0 none, 1 I-cache, 2 D-cache
  bit   m_last_d;
  int   m_ig, m_dg;
  bit   i_pend, d_pend, busy;
  int   cnt;

  initial begin
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = IA; d_address = DA; d_wdata = WD; pmem_rdata = RD;
    @(posedge clk);

    //                 rst i d w rsp  pr pw ir dr addr  wd  ig dg
    vecs.push_back(mk(1, 0,0,0,0,  0,0,0,0, 16'h0, 0, 0,0));  // reset state
    vecs.push_back(mk(0, 1,0,0,0,  0,0,0,0, 16'h0, 0, 0,0));  // I request seen
    vecs.push_back(mk(0, 1,0,0,0,  1,0,0,0, IA,    0, 1,0));
    vecs.push_back(mk(0, 1,0,0,0,  1,0,0,0, IA,    0, 1,0));
    vecs.push_back(mk(0, 1,0,0,0,  1,0,0,0, IA,    0, 1,0));
    vecs.push_back(mk(0, 1,0,0,1,  1,0,1,0, IA,    0, 1,0));  // I resp
    vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0, 16'h0, 0, 1,0));
    vecs.push_back(mk(0, 0,0,1,0,  0,0,0,0, 16'h0, 0, 1,0));  // D write
    vecs.push_back(mk(0, 0,0,1,0,  0,1,0,0, DA,    1, 1,1));
    vecs.push_back(mk(0, 0,0,1,1,  0,1,0,1, DA,    1, 1,1));
    vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0, 16'h0, 0, 1,1));
    vecs.push_back(mk(1, 0,0,0,0,  0,0,0,0, 16'h0, 0, 1,1));  // reset again
    vecs.push_back(mk(0, 1,1,0,0,  0,0,0,0, 16'h0, 0, 0,0));  // tie -> D
    vecs.push_back(mk(0, 1,1,0,0,  1,0,0,0, DA,    1, 0,1));
    vecs.push_back(mk(0, 1,1,0,1,  1,0,0,1, DA,    1, 0,1));
    vecs.push_back(mk(0, 1,1,0,0,  0,0,0,0, 16'h0, 0, 0,1));  // fresh tie -> I
    vecs.push_back(mk(0, 1,1,0,1,  1,0,1,0, IA,    0, 1,1));
    vecs.push_back(mk(0, 1,1,0,0,  0,0,0,0, 16'h0, 0, 1,1));  // tie -> D
    vecs.push_back(mk(0, 1,1,0,0,  1,0,0,0, DA,    1, 1,2));
    vecs.push_back(mk(1, 1,1,0,0,  1,0,0,0, DA,    1, 1,2));  // reset mid-serve
    vecs.push_back(mk(0, 0,0,0,1,  0,0,0,0, 16'h0, 0, 0,0));  // late resp ignored
    vecs.push_back(mk(0, 0,0,1,0,  0,0,0,0, 16'h0, 0, 0,0));
    vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0, DA,    1, 0,1));  // request dropped
    vecs.push_back(mk(0, 0,0,0,1,  0,0,0,1, DA,    1, 0,1));  // still completes
    vecs.push_back(mk(0, 0,0,0,0,  0,0,0,0, 16'h0, 0, 0,1));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst = vecs[k].rst; i_read = vecs[k].ir; d_read = vecs[k].dr;
      d_write = vecs[k].dw; pmem_resp = vecs[k].presp;
      #1;
      chk($sformatf("row%0d", k), dut_pk(),
          pk(vecs[k].e_pr, vecs[k].e_pw, vecs[k].e_ir, vecs[k].e_dr, vecs[k].e_addr,
             vecs[k].e_wd ? WD : '0, vecs[k].e_ig, vecs[k].e_dg, RD, RD));
    end

    // randomized traffic against a transaction-level model
    @(negedge clk);
    rst = 1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    m_own = 0; m_last_d = 0; m_ig = 0; m_dg = 0;
    i_pend = 0; d_pend = 0; busy = 0; cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic e_pr, e_pw, e_ir, e_dr;
      lc3b_word e_a;
      lc3b_c_line e_wd;
      @(negedge clk);
      rst = (($urandom % 150) == 0);
      if (!i_pend && ($urandom % 3) == 0) begin
        i_pend = 1; i_address = 16'($urandom);
      end
      if (!d_pend && ($urandom % 3) == 0) begin
        d_pend = 1; d_address = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        d_write = 1'($urandom);
        d_read = ~d_write;
      end
      i_read = i_pend;
      if (!d_pend) begin d_read = 0; d_write = 0; end
      pmem_resp = busy && (cnt == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      e_pr = 0; e_pw = 0; e_ir = 0; e_dr = 0; e_a = '0; e_wd = '0;
      if (m_own == 1) begin
        e_pr = i_read; e_a = i_address; e_ir = pmem_resp;
      end else if (m_own == 2) begin
        e_pw = d_write; e_pr = d_read && !d_write; e_a = d_address;
        e_wd = d_wdata; e_dr = pmem_resp;
      end
      chk($sformatf("rand%0d", c), dut_pk(),
          pk(e_pr, e_pw, e_ir, e_dr, e_a, e_wd,
             16'((m_ig > 65535) ? 65535 : m_ig), 16'((m_dg > 65535) ? 65535 : m_dg),
             pmem_rdata, pmem_rdata));
      // requesters see their completion and drop next cycle
      if (m_own == 1 && pmem_resp) i_pend = 0;
      if (m_own == 2 && pmem_resp) d_pend = 0;
      // memory: accept a strobe, answer 1..3 cycles later
      if (rst) busy = 0;
      else if (pmem_resp) busy = 0;
      else if (busy) cnt--;
      else if (pmem_read || pmem_write) begin busy = 1; cnt = $urandom_range(0, 2); end
      // arbitration model for the coming edge
      if (rst) begin
        m_own = 0; m_last_d = 0; m_ig = 0; m_dg = 0;
      end else if (m_own == 0) begin
        if (i_read && (d_read || d_write)) m_own = m_last_d ? 1 : 2;
        else if (i_read)                   m_own = 1;
        else if (d_read || d_write)        m_own = 2;
        if (m_own == 1) begin m_ig++; m_last_d = 0; end
        if (m_own == 2) begin m_dg++; m_last_d = 1; end
      end else if (pmem_resp) m_own = 0;
    end

    // saturation of d_grants
    @(negedge clk);
    rst = 1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    d_address = DA; d_wdata = WD; pmem_rdata = RD;
    @(negedge clk);
    rst = 0;
    force dut.u_d_cnt.r_count = 16'hFFFE;
    @(negedge clk);
    release dut.u_d_cnt.r_count;
    #1;
    chk("preload", {496'b0, d_grants}, {496'b0, 16'hFFFE});
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      d_write = 1; pmem_resp = 0;
      @(negedge clk);
      pmem_resp = 1;
      #1;
      chk($sformatf("sat_resp%0d", t), {510'b0, d_resp, pmem_write}, {510'b0, 2'b11});
      @(negedge clk);
      d_write = 0; pmem_resp = 0;
      #1;
      chk($sformatf("sat%0d", t), {480'b0, i_grants, d_grants}, {480'b0, 16'h0, 16'hFFFF});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
